// File: rtl/nunchuck_responder.sv
// nunchuck_responder
//   I2C target that emulates a Nunchuck. Packs the stick, accelerometer and
//   button fields into the 6-byte Nunchuck report. Serves the report to a bus
//   master, starting at a register pointer that the master can set with a write.
//
// Ports
//   clk        system clock, at least 16x the SCL frequency
//   rst        asynchronous, active-high reset
//   scl        bus clock pin (sensed only, no clock stretching)
//   sda_in     bus data pin, sensed value
//   sda_oe     1 = pull SDA low (open drain), 0 = release
//   stick_x/y  joystick axes, 8 bits each
//   accel_x/y/z accelerometer axes, 10 bits each
//   z, c       button bits
//   busy       high from an address match until STOP
//   xfer_done  one-clock pulse on the STOP that ends an addressed transaction
module nunchuck_responder #(
   parameter logic [6:0] DEV_ADDR    = 7'h52,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic [7:0] stick_x,
   input  logic [7:0] stick_y,
   input  logic [9:0] accel_x,
   input  logic [9:0] accel_y,
   input  logic [9:0] accel_z,
   input  logic       z,
   input  logic       c,
   output logic       busy,
   output logic       xfer_done
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
   } state_t;

   // Input synchronisers; they reset to the idle bus level (both lines high).
   logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
   logic scl_prev_reg, sda_prev_reg;
   logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

   state_t      state_reg, state_next;
   logic [3:0]  bit_cnt_reg, bit_cnt_next;
   logic [7:0]  shift_reg, shift_next;
   logic [2:0]  reg_ptr_reg, reg_ptr_next;
   logic [47:0] snapshot_reg;
   logic        sda_oe_reg, sda_oe_next;
   logic        busy_reg, busy_next;
   logic        xfer_done_reg, xfer_done_next;
   logic        ack_drv_reg, ack_drv_next;     // ACK slot: 0 = waiting to drive, 1 = driving
   logic        rw_reg, rw_next;
   logic        first_wr_reg, first_wr_next;   // next written byte is the register pointer
   logic        snap_load;
   logic [47:0] packed_report;
   logic [7:0]  shift_in, rd_byte;
   logic        rd_bit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_reg <= '1;
         sda_sync_reg <= '1;
         scl_prev_reg <= 1'b1;
         sda_prev_reg <= 1'b1;
      end else begin
         scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl};
         sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
         scl_prev_reg <= scl_sync_reg[SYNC_STAGES-1];
         sda_prev_reg <= sda_sync_reg[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
   assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev_reg;
   assign scl_fall  = ~scl_s & scl_prev_reg;
   assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
   assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;
   assign shift_in  = {shift_reg[6:0], sda_s};

   // Byte 5 carries the accelerometer LSBs in bit-reversed pairs.
   assign packed_report = {stick_x, stick_y, accel_x[9:2], accel_y[9:2], accel_z[9:2],
                           z, c, accel_x[0], accel_x[1], accel_y[0], accel_y[1],
                           accel_z[0], accel_z[1]};

   always_comb begin
      rd_byte = snapshot_reg[47:40];
      case (reg_ptr_reg)
         3'd1:    rd_byte = snapshot_reg[39:32];
         3'd2:    rd_byte = snapshot_reg[31:24];
         3'd3:    rd_byte = snapshot_reg[23:16];
         3'd4:    rd_byte = snapshot_reg[15:8];
         3'd5:    rd_byte = snapshot_reg[7:0];
         default: rd_byte = snapshot_reg[47:40];
      endcase
   end

   // bit_cnt counts bits already driven in RD_BYTE, so the next bit is MSB-first.
   assign rd_bit = rd_byte[3'd7 - bit_cnt_reg[2:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         reg_ptr_reg   <= '0;
         snapshot_reg  <= '0;
         sda_oe_reg    <= 1'b0;
         busy_reg      <= 1'b0;
         xfer_done_reg <= 1'b0;
         ack_drv_reg   <= 1'b0;
         rw_reg        <= 1'b0;
         first_wr_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bit_cnt_reg   <= bit_cnt_next;
         shift_reg     <= shift_next;
         reg_ptr_reg   <= reg_ptr_next;
         if (snap_load)
            snapshot_reg <= packed_report;
         sda_oe_reg    <= sda_oe_next;
         busy_reg      <= busy_next;
         xfer_done_reg <= xfer_done_next;
         ack_drv_reg   <= ack_drv_next;
         rw_reg        <= rw_next;
         first_wr_reg  <= first_wr_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      bit_cnt_next   = bit_cnt_reg;
      shift_next     = shift_reg;
      reg_ptr_next   = reg_ptr_reg;
      sda_oe_next    = sda_oe_reg;
      busy_next      = busy_reg;
      xfer_done_next = 1'b0;
      ack_drv_next   = ack_drv_reg;
      rw_next        = rw_reg;
      first_wr_next  = first_wr_reg;
      snap_load      = 1'b0;

      if (stop_det) begin
         state_next     = IDLE;
         sda_oe_next    = 1'b0;
         xfer_done_next = busy_reg;
         busy_next      = 1'b0;
      end else if (start_det) begin
         // Also covers repeated START; the register pointer is kept.
         state_next   = ADDR;
         bit_cnt_next = '0;
         sda_oe_next  = 1'b0;
      end else begin
         case (state_reg)
            IDLE: ;
            ADDR: begin
               if (scl_rise) begin
                  shift_next = shift_in;
                  if (bit_cnt_reg == 4'd7) begin
                     bit_cnt_next = '0;
                     if (shift_reg[6:0] == DEV_ADDR) begin
                        state_next    = ADDR_ACK;
                        busy_next     = 1'b1;
                        ack_drv_next  = 1'b0;
                        rw_next       = sda_s;
                        first_wr_next = ~sda_s;
                        snap_load     = sda_s;
                     end else begin
                        state_next = WAIT_STOP;
                     end
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 4'd1;
                  end
               end
            end
            ADDR_ACK, WR_ACK: begin
               // First fall after the 8th bit starts the ACK, the next fall ends it.
               if (scl_fall) begin
                  if (!ack_drv_reg) begin
                     sda_oe_next  = 1'b1;
                     ack_drv_next = 1'b1;
                  end else begin
                     ack_drv_next = 1'b0;
                     bit_cnt_next = '0;
                     if (state_reg == ADDR_ACK && rw_reg) begin
                        // The ACK-ending fall also launches the first data MSB.
                        state_next   = RD_BYTE;
                        sda_oe_next  = ~rd_bit;
                        bit_cnt_next = 4'd1;
                     end else begin
                        state_next  = WR_BYTE;
                        sda_oe_next = 1'b0;
                     end
                  end
               end
            end
            WR_BYTE: begin
               if (scl_rise) begin
                  shift_next = shift_in;
                  if (bit_cnt_reg == 4'd7) begin
                     state_next   = WR_ACK;
                     ack_drv_next = 1'b0;
                     bit_cnt_next = '0;
                     if (first_wr_reg) begin
                        reg_ptr_next  = (shift_in > 8'd5) ? 3'd0 : shift_in[2:0];
                        first_wr_next = 1'b0;
                     end
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 4'd1;
                  end
               end
            end
            RD_BYTE: begin
               if (scl_fall) begin
                  if (bit_cnt_reg == 4'd8) begin
                     state_next   = RD_ACK;
                     sda_oe_next  = 1'b0;
                     reg_ptr_next = (reg_ptr_reg == 3'd5) ? 3'd0 : reg_ptr_reg + 3'd1;
                  end else begin
                     sda_oe_next  = ~rd_bit;
                     bit_cnt_next = bit_cnt_reg + 4'd1;
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  if (!sda_s) begin
                     state_next   = RD_BYTE;
                     bit_cnt_next = '0;
                  end else begin
                     state_next  = WAIT_STOP;
                     sda_oe_next = 1'b0;
                  end
               end
            end
            WAIT_STOP: sda_oe_next = 1'b0;
            default:   state_next = IDLE;
         endcase
      end
   end

   assign sda_oe    = sda_oe_reg;
   assign busy      = busy_reg;
   assign xfer_done = xfer_done_reg;

endmodule

// File: tb/tb_nunchuck_responder.sv
// Testbench for nunchuck_responder. A bus master drives directed I2C
// transactions and pushes the expected ACK or data for every 9-bit frame.
// A separate bus sniffer pops the queue and compares each frame it observes.
module tb_nunchuck_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_pin;
   logic       sda_m;
   logic       sda_line;
   logic       sda_oe;
   logic [7:0] stick_x, stick_y;
   logic [9:0] accel_x, accel_y, accel_z;
   logic       z, c;
   logic       busy, xfer_done;

   assign sda_line = sda_m & ~sda_oe;

   nunchuck_responder dut (
      .clk(clk), .rst(rst), .scl(scl_pin), .sda_in(sda_line), .sda_oe(sda_oe),
      .stick_x(stick_x), .stick_y(stick_y),
      .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
      .z(z), .c(c), .busy(busy), .xfer_done(xfer_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         rd;     // 1: compare data byte, 0: compare ACK bit
      logic [7:0] val;
      logic       ack;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks  = 0;
   int   n_pass    = 0;
   int   done_cnt  = 0;
   int   exp_done  = 0;
   int   nd_viol   = 0;
   int   edge_viol = 0;
   bit   nodrive   = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
   endtask

   task automatic push_frame(input bit rd, input logic [7:0] val, input logic ack, input string name);
      exp_t e;
      e.rd = rd; e.val = val; e.ack = ack; e.name = name;
      exp_q.push_back(e);
   endtask

   // Bus sniffer: decodes START/STOP and 9-bit frames from the wired bus.
   initial begin
      logic scl_q, sda_q;
      logic [7:0] sh;
      int bitn;
      exp_t e;
      scl_q = 1'b1; sda_q = 1'b1; sh = '0; bitn = 0;
      forever begin
         @(scl_pin or sda_line);
         if (scl_pin && scl_q && sda_q && !sda_line) bitn = 0;
         else if (scl_pin && scl_q && !sda_q && sda_line) bitn = 0;
         else if (scl_pin && !scl_q) begin
            if (bitn < 8) begin
               sh = {sh[6:0], sda_line};
               bitn++;
            end else begin
               bitn = 0;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_frame: got byte %02h, expected no frame", sh);
               end else begin
                  e = exp_q.pop_front();
                  if (e.rd) check(e.name, {8'h00, sh}, {8'h00, e.val});
                  else      check(e.name, {15'h0, sda_line}, {15'h0, e.ack});
               end
            end
         end
         scl_q = scl_pin;
         sda_q = sda_line;
      end
   end

   // Pulse counter and drive-window observers, sampled mid-cycle.
   initial begin
      logic oe_q;
      oe_q = 1'b0;
      forever begin
         @(negedge clk);
         if (xfer_done === 1'b1) done_cnt++;
         if (sda_oe !== oe_q && scl_pin) edge_viol++;
         if (nodrive && sda_oe === 1'b1) nd_viol++;
         oe_q = sda_oe;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "timeout");
   end

   task automatic q();
      repeat (8) @(posedge clk);
      #2;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; q();
      scl_pin = 1'b1; q();
      sda_m = 1'b0; q();
      scl_pin = 1'b0; q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; q();
      scl_pin = 1'b1; q();
      sda_m = 1'b1; q();
   endtask

   task automatic clock_bit(input logic b);
      sda_m = b; q();
      scl_pin = 1'b1; q(); q();
      scl_pin = 1'b0; q();
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) clock_bit(b[i]);
      clock_bit(1'b1);
   endtask

   task automatic recv_byte(input logic nack);
      for (int i = 0; i < 8; i++) clock_bit(1'b1);
      clock_bit(nack);
   endtask

   task automatic stop_check(input bit expect_pulse, input string tag);
      i2c_stop();
      q();
      if (expect_pulse) exp_done++;
      check({tag, "_xfer_done"}, 16'(done_cnt), 16'(exp_done));
      check({tag, "_busy_after_stop"}, {15'h0, busy}, 16'h0);
   endtask

   task automatic set_inputs(input logic [7:0] sx, input logic [7:0] sy, input logic [9:0] ax,
                             input logic [9:0] ay, input logic [9:0] az, input logic zz, input logic cc);
      stick_x = sx; stick_y = sy; accel_x = ax; accel_y = ay; accel_z = az; z = zz; c = cc;
   endtask

   task automatic do_write(input logic [7:0] ptr, input string tag);
      i2c_start();
      push_frame(0, 8'hA4, 1'b0, {tag, "_addr_ack"});
      send_byte(8'hA4);
      push_frame(0, ptr, 1'b0, {tag, "_data_ack"});
      send_byte(ptr);
      stop_check(1, tag);
   endtask

   task automatic do_read(input int n, input logic [63:0] bytes_exp, input bit perturb, input string tag);
      i2c_start();
      push_frame(0, 8'hA5, 1'b0, {tag, "_addr_ack"});
      send_byte(8'hA5);
      check({tag, "_busy"}, {15'h0, busy}, 16'h1);
      if (perturb) set_inputs(8'h11, 8'h22, 10'h155, 10'h2AA, 10'h0F0, 1'b0, 1'b1);
      for (int k = 0; k < n; k++) begin
         push_frame(1, bytes_exp[63-8*k -: 8], 1'b0, $sformatf("%s_byte%0d", tag, k));
         recv_byte(k == n - 1);
      end
      nodrive = 1'b1;
      stop_check(1, tag);
      nodrive = 1'b0;
      check({tag, "_no_drive_after_nack"}, 16'(nd_viol), 16'h0);
   endtask

   initial begin
      rst = 1'b1; scl_pin = 1'b1; sda_m = 1'b1;
      set_inputs(8'h80, 8'h7F, 10'h201, 10'h102, 10'h3FF, 1'b1, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("reset_sda_oe", {15'h0, sda_oe}, 16'h0);
      check("reset_busy", {15'h0, busy}, 16'h0);
      check("reset_xfer_done", {15'h0, xfer_done}, 16'h0);
      @(posedge clk); #2 rst = 1'b0;
      q();

      // T1: set pointer 0, read all six bytes
      do_write(8'h00, "t1w");
      do_read(6, 64'h807F_8040_FFA7_0000, 0, "t1r");

      // T2: wrong address is never acknowledged or driven
      i2c_start();
      nodrive = 1'b1;
      push_frame(0, 8'hA6, 1'b1, "t2_addr_nack");
      send_byte(8'hA6);
      check("t2_busy", {15'h0, busy}, 16'h0);
      stop_check(0, "t2");
      nodrive = 1'b0;
      check("t2_no_drive", 16'(nd_viol), 16'h0);

      // T3: inputs changed after the address ACK do not reach this read
      do_read(6, 64'h807F_8040_FFA7_0000, 1, "t3");
      set_inputs(8'h80, 8'h7F, 10'h201, 10'h102, 10'h3FF, 1'b1, 1'b0);

      // T4: wrap after byte 5; out-of-range pointer write selects byte 0
      do_read(8, 64'h807F_8040_FFA7_807F, 0, "t4");
      do_write(8'h07, "t4w");
      do_read(2, 64'h807F_0000_0000_0000, 0, "t4b");

      // T5: pointer persists across transactions
      do_write(8'h00, "t5w");
      do_read(3, 64'h807F_8000_0000_0000, 0, "t5a");
      do_read(1, 64'h4000_0000_0000_0000, 0, "t5b");

      // T6: repeated START after a pointer write
      i2c_start();
      push_frame(0, 8'hA4, 1'b0, "t6_addr_w_ack");
      send_byte(8'hA4);
      push_frame(0, 8'h02, 1'b0, "t6_ptr_ack");
      send_byte(8'h02);
      i2c_start();
      push_frame(0, 8'hA5, 1'b0, "t6_addr_r_ack");
      send_byte(8'hA5);
      check("t6_busy", {15'h0, busy}, 16'h1);
      push_frame(1, 8'h80, 1'b0, "t6_byte0");
      recv_byte(1'b0);
      push_frame(1, 8'h40, 1'b0, "t6_byte1");
      recv_byte(1'b1);
      nodrive = 1'b1;
      stop_check(1, "t6");
      nodrive = 1'b0;

      // T6 reset case: reset while driving bit 3 of byte 2 (0x00)
      do_write(8'h02, "t6r_w");
      set_inputs(8'h80, 8'h7F, 10'h000, 10'h102, 10'h3FF, 1'b1, 1'b0);
      i2c_start();
      push_frame(0, 8'hA5, 1'b0, "t6r_addr_ack");
      send_byte(8'hA5);
      for (int i = 0; i < 4; i++) clock_bit(1'b1);
      check("t6r_drive_before_rst", {15'h0, sda_oe}, 16'h1);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      check("t6r_sda_oe_same_cycle", {15'h0, sda_oe}, 16'h0);
      check("t6r_busy", {15'h0, busy}, 16'h0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      sda_m = 1'b0; q();
      scl_pin = 1'b1; q();
      sda_m = 1'b1; q(); q();
      check("t6r_no_done_after_rst", 16'(done_cnt), 16'(exp_done));
      set_inputs(8'h5A, 8'h7F, 10'h201, 10'h102, 10'h3FF, 1'b1, 1'b0);
      do_read(1, 64'h5A00_0000_0000_0000, 0, "t6r_ptr0");

      q();
      check("frames_pending", 16'(exp_q.size()), 16'h0);
      check("sda_oe_stable_while_scl_high", 16'(edge_viol), 16'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
